// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and access-size helpers for the load/store unit
package riscv_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LH       = 4'd2,
        LW       = 4'd3,
        LD       = 4'd4,
        LBU      = 4'd5,
        LHU      = 4'd6,
        LWU      = 4'd7,
        SB       = 4'd8,
        SH       = 4'd9,
        SW       = 4'd10,
        SD       = 4'd11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_t;

    function automatic logic is_store(mem_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] op_size(mem_op_t op);
        case (op)
            LH, LHU, SH: return 2'd1;
            LW, LWU, SW: return 2'd2;
            LD, SD:      return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic is_aligned(mem_op_t op, logic [2:0] off);
        case (op_size(op))
            2'd1:    return off[0] == 1'b0;
            2'd2:    return off[1:0] == 2'b00;
            2'd3:    return off == 3'b000;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] byte_en(mem_op_t op, logic [2:0] off);
        case (op_size(op))
            2'd1:    return 8'h03 << off;
            2'd2:    return 8'h0F << off;
            2'd3:    return 8'hFF;
            default: return 8'h01 << off;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the load lane from a 64-bit beat and sign/zero extends it
module load_align
    import riscv_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] rdata_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = '0;
        case (op_i)
            LB:      data_o = {{56{shifted[7]}},  shifted[7:0]};
            LH:      data_o = {{48{shifted[15]}}, shifted[15:0]};
            LW:      data_o = {{32{shifted[31]}}, shifted[31:0]};
            LD:      data_o = shifted;
            LBU:     data_o = {56'd0, shifted[7:0]};
            LHU:     data_o = {48'd0, shifted[15:0]};
            LWU:     data_o = {32'd0, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - MEM stage: single outstanding data-memory access with alignment and timeout faults
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [63:0] ex_result_i,
    input  logic [63:0] ex_store_data_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_reg_write_i,
    input  mem_op_t     ex_mem_op_i,
    output logic        dmem_req_o,
    input  logic        dmem_gnt_i,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [7:0]  dmem_be_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [63:0] wb_data_o,
    output logic        wb_reg_write_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [63:0] fault_addr_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       addr_q;
    mem_op_t           op_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic              req_q, we_q;
    logic [63:0]       daddr_q, wdata_q;
    logic [7:0]        be_q;
    logic              wb_valid_q, wb_rw_q, misalign_q, bus_err_q;
    logic [4:0]        wb_rd_q;
    logic [63:0]       wb_data_q, fault_addr_q;
    logic [63:0]       load_data;
    logic              tmo_hit;

    load_align u_load_align (
        .op_i    (op_q),
        .off_i   (addr_q[2:0]),
        .rdata_i (dmem_rdata_i),
        .data_o  (load_data)
    );

    assign tmo_hit = (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            op_q         <= MEM_NONE;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            daddr_q      <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_rw_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            // Status outputs are single-cycle pulses unless set below
            wb_valid_q   <= 1'b0;
            wb_rw_q      <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            fault_addr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (ex_valid_i) begin
                        addr_q <= ex_result_i;
                        op_q   <= ex_mem_op_i;
                        rd_q   <= ex_rd_addr_i;
                        rw_q   <= ex_reg_write_i && (ex_rd_addr_i != 5'd0);
                        if (ex_mem_op_i == MEM_NONE) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ex_result_i;
                            wb_rd_q    <= ex_rd_addr_i;
                            wb_rw_q    <= ex_reg_write_i && (ex_rd_addr_i != 5'd0);
                        end else if (!is_aligned(ex_mem_op_i, ex_result_i[2:0])) begin
                            misalign_q   <= 1'b1;
                            fault_addr_q <= ex_result_i;
                            wb_valid_q   <= 1'b1;
                            wb_data_q    <= '0;
                            wb_rd_q      <= ex_rd_addr_i;
                        end else begin
                            state_q <= REQ;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                            we_q    <= is_store(ex_mem_op_i);
                            daddr_q <= {ex_result_i[63:3], 3'b000};
                            be_q    <= byte_en(ex_mem_op_i, ex_result_i[2:0]);
                            wdata_q <= ex_store_data_i << {ex_result_i[2:0], 3'b000};
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i || tmo_hit) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        daddr_q <= '0;
                        be_q    <= '0;
                        wdata_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (dmem_gnt_i) begin
                        if (is_store(op_q)) begin
                            state_q    <= IDLE;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= '0;
                            wb_rd_q    <= rd_q;
                        end else begin
                            state_q <= WAIT_RSP;
                        end
                    end else if (tmo_hit) begin
                        state_q      <= IDLE;
                        bus_err_q    <= 1'b1;
                        fault_addr_q <= addr_q;
                        wb_valid_q   <= 1'b1;
                        wb_data_q    <= '0;
                        wb_rd_q      <= rd_q;
                    end
                end
                WAIT_RSP: begin
                    if (dmem_rvalid_i) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_data;
                        wb_rd_q    <= rd_q;
                        wb_rw_q    <= rw_q;
                    end else if (tmo_hit) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        bus_err_q    <= 1'b1;
                        fault_addr_q <= addr_q;
                        wb_valid_q   <= 1'b1;
                        wb_data_q    <= '0;
                        wb_rd_q      <= rd_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ex_ready_o     = (state_q == IDLE);
    assign dmem_req_o     = req_q;
    assign dmem_we_o      = we_q;
    assign dmem_addr_o    = daddr_q;
    assign dmem_be_o      = be_q;
    assign dmem_wdata_o   = wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_rd_addr_o   = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_reg_write_o = wb_rw_q;
    assign misalign_o     = misalign_q;
    assign bus_err_o      = bus_err_q;
    assign fault_addr_o   = fault_addr_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized and directed bench for lsu against a byte-lane reference model
module tb_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_ready_o;
    logic [63:0] ex_result_i, ex_store_data_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_reg_write_i;
    mem_op_t     ex_mem_op_i;
    logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_be_o;
    logic        dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        wb_valid_o, wb_reg_write_o, misalign_o, bus_err_o;
    logic [4:0]  wb_rd_addr_o;
    logic [63:0] wb_data_o, fault_addr_o;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_result_i(ex_result_i), .ex_store_data_i(ex_store_data_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_write_i(ex_reg_write_i), .ex_mem_op_i(ex_mem_op_i),
        .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
        .wb_reg_write_o(wb_reg_write_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .fault_addr_o(fault_addr_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_bytes(mem_op_t op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, LWU, SW: return 4;
            default:     return 8;
        endcase
    endfunction

    function automatic logic [63:0] model_load(mem_op_t op, logic [63:0] addr, logic [63:0] rdata);
        int sz = size_bytes(op);
        logic [63:0] v, mask;
        v = rdata >> (8 * addr[2:0]);
        mask = (sz == 8) ? '1 : ((64'd1 << (8 * sz)) - 64'd1);
        v = v & mask;
        if ((op == LB || op == LH || op == LW) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic issue(mem_op_t op, logic [63:0] addr, logic [63:0] sdata, logic [4:0] rd, logic rw);
        ex_valid_i = 1'b1; ex_mem_op_i = op; ex_result_i = addr;
        ex_store_data_i = sdata; ex_rd_addr_i = rd; ex_reg_write_i = rw;
        checks++;
        if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b want 1", ex_ready_o); end
        step();
        ex_valid_i = 1'b0;
    endtask

    // One memory transaction; noise drives rvalid/rdata garbage outside WAIT_RSP
    task automatic run_txn(mem_op_t op, logic [63:0] addr, logic [63:0] sdata, logic [4:0] rd,
                           logic rw, int gnt_dly, int rsp_dly, logic [63:0] rdata, logic noise);
        int sz = size_bytes(op);
        int off = int'(addr[2:0]);
        int be_int = ((1 << sz) - 1) << off;
        logic [7:0] exp_be = be_int[7:0];
        logic [63:0] lane_mask = '0;
        logic [63:0] exp_wd = sdata << (8 * off);
        logic st = (op == SB || op == SH || op == SW || op == SD);
        for (int b = 0; b < 8; b++) if (exp_be[b]) lane_mask[8*b +: 8] = 8'hFF;
        issue(op, addr, sdata, rd, rw);
        if ((addr % 64'(sz)) != 0) begin
            checks++;
            if (dmem_req_o !== 1'b0 || misalign_o !== 1'b1 || fault_addr_o !== addr ||
                wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL misalign: req=%b mis=%b fa=%h wbv=%b wbrw=%b rdy=%b want 0 1 %h 1 0 1",
                         dmem_req_o, misalign_o, fault_addr_o, wb_valid_o, wb_reg_write_o, ex_ready_o, addr);
            end
            step();
            checks++;
            if (misalign_o !== 1'b0 || wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin
                errors++; $display("FAIL misalign_pulse: mis=%b wbv=%b req=%b want 0", misalign_o, wb_valid_o, dmem_req_o);
            end
            return;
        end
        for (int c = 0; c <= gnt_dly; c++) begin
            dmem_gnt_i = (c == gnt_dly);
            dmem_rvalid_i = noise; dmem_rdata_i = $urandom();
            checks++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== st || dmem_addr_o !== {addr[63:3], 3'b000} ||
                dmem_be_o !== exp_be || (dmem_wdata_o & lane_mask & {64{st}}) !== (exp_wd & lane_mask & {64{st}}) ||
                ex_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL req_phase: req=%b we=%b addr=%h be=%h wd=%h rdy=%b want 1 %b %h %h %h 0",
                         dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, ex_ready_o,
                         st, {addr[63:3], 3'b000}, exp_be, exp_wd);
            end
            step();
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        if (st) begin
            checks++;
            if (wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || dmem_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL store_done: wbv=%b wbrw=%b req=%b rdy=%b want 1 0 0 1",
                         wb_valid_o, wb_reg_write_o, dmem_req_o, ex_ready_o);
            end
        end else begin
            for (int c = 0; c < rsp_dly; c++) begin
                checks++;
                if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0 || ex_ready_o !== 1'b0) begin
                    errors++; $display("FAIL wait_rsp: wbv=%b req=%b rdy=%b want 0 0 0", wb_valid_o, dmem_req_o, ex_ready_o);
                end
                step();
            end
            dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
            step();
            dmem_rvalid_i = 1'b0;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_data_o !== model_load(op, addr, rdata) || wb_rd_addr_o !== rd ||
                wb_reg_write_o !== (rw && rd != 5'd0) || ex_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL load_done op=%0d addr=%h: wbv=%b data=%h rd=%0d rw=%b want 1 %h %0d %b",
                         op, addr, wb_valid_o, wb_data_o, wb_rd_addr_o, wb_reg_write_o,
                         model_load(op, addr, rdata), rd, rw && rd != 5'd0);
            end
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b0 || bus_err_o !== 1'b0) begin
            errors++; $display("FAIL wb_pulse: wbv=%b berr=%b want 0 0", wb_valid_o, bus_err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        checks++;
        if (ex_ready_o !== 1'b1 || dmem_req_o !== 1'b0 || dmem_we_o !== 1'b0 || dmem_addr_o !== '0 ||
            dmem_be_o !== '0 || dmem_wdata_o !== '0 || wb_valid_o !== 1'b0 || wb_data_o !== '0 ||
            wb_rd_addr_o !== '0 || wb_reg_write_o !== 1'b0 || misalign_o !== 1'b0 ||
            bus_err_o !== 1'b0 || fault_addr_o !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%b req=%b wbv=%b data=%h mis=%b berr=%b fa=%h want 1 and zeros",
                     ex_ready_o, dmem_req_o, wb_valid_o, wb_data_o, misalign_o, bus_err_o, fault_addr_o);
        end
    endtask

    task automatic test_mem_none();
        issue(MEM_NONE, 64'h1234, 64'h0, 5'd5, 1'b1);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 64'h1234 || wb_reg_write_o !== 1'b1 ||
            wb_rd_addr_o !== 5'd5 || dmem_req_o !== 1'b0) begin
            errors++; $display("FAIL mem_none: wbv=%b data=%h rw=%b rd=%0d want 1 1234 1 5",
                               wb_valid_o, wb_data_o, wb_reg_write_o, wb_rd_addr_o);
        end
        issue(MEM_NONE, 64'hDEAD, 64'h0, 5'd0, 1'b1);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 64'hDEAD || wb_reg_write_o !== 1'b0) begin
            errors++; $display("FAIL rd_zero: wbv=%b data=%h rw=%b want 1 dead 0", wb_valid_o, wb_data_o, wb_reg_write_o);
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mem_none_pulse: wbv=%b want 0", wb_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r0 = {$urandom(), $urandom()};
        logic [63:0] r1 = {$urandom(), $urandom()};
        issue(MEM_NONE, r0, 64'h0, 5'd7, 1'b1);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== r0 || wb_rd_addr_o !== 5'd7) begin
            errors++; $display("FAIL b2b_first: wbv=%b data=%h want 1 %h", wb_valid_o, wb_data_o, r0);
        end
        issue(MEM_NONE, r1, 64'h0, 5'd9, 1'b0);
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== r1 || wb_rd_addr_o !== 5'd9 || wb_reg_write_o !== 1'b0) begin
            errors++; $display("FAIL b2b_second: wbv=%b data=%h rw=%b want 1 %h 0", wb_valid_o, wb_data_o, wb_reg_write_o, r1);
        end
        step();
    endtask

    task automatic test_directed();
        run_txn(LB, 64'h1003, 64'h0, 5'd3, 1'b1, 2, 0, 64'h0000_0000_8000_0000, 1'b1);
        run_txn(SH, 64'h2006, 64'hBEEF, 5'd4, 1'b1, 1, 0, 64'h0, 1'b0);
        run_txn(LW, 64'h3002, 64'h0, 5'd6, 1'b1, 0, 0, 64'h0, 1'b0);
        run_txn(LD, 64'h4000, 64'h0, 5'd8, 1'b1, 3, 3, 64'h0123_4567_89AB_CDEF, 1'b1);
    endtask

    task automatic test_timeout();
        // Grant, then no response: bus error after four WAIT_RSP cycles
        issue(LD, 64'h5008, 64'h0, 5'd10, 1'b1);
        dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus_err_o !== 1'b0 || ex_ready_o !== 1'b0) begin
                errors++; $display("FAIL tmo_early c=%0d: berr=%b rdy=%b want 0 0", c, bus_err_o, ex_ready_o);
            end
            step();
        end
        checks++;
        if (bus_err_o !== 1'b1 || fault_addr_o !== 64'h5008 || ex_ready_o !== 1'b1 ||
            wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 || dmem_req_o !== 1'b0) begin
            errors++; $display("FAIL tmo_rsp: berr=%b fa=%h rdy=%b wbv=%b rw=%b want 1 5008 1 1 0",
                               bus_err_o, fault_addr_o, ex_ready_o, wb_valid_o, wb_reg_write_o);
        end
        step();
        checks++;
        if (bus_err_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse: berr=%b want 0", bus_err_o); end
        // No grant at all: request dropped after four REQ cycles
        issue(SW, 64'h6004, 64'h55, 5'd1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dmem_req_o !== 1'b1 || bus_err_o !== 1'b0) begin
                errors++; $display("FAIL tmo_req_hold c=%0d: req=%b berr=%b want 1 0", c, dmem_req_o, bus_err_o);
            end
            step();
        end
        checks++;
        if (bus_err_o !== 1'b1 || dmem_req_o !== 1'b0 || fault_addr_o !== 64'h6004 || ex_ready_o !== 1'b1) begin
            errors++; $display("FAIL tmo_req: berr=%b req=%b fa=%h rdy=%b want 1 0 6004 1",
                               bus_err_o, dmem_req_o, fault_addr_o, ex_ready_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(LW, 64'h7004, 64'h0, 5'd12, 1'b1);
        dmem_gnt_i = 1'b1; step(); dmem_gnt_i = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF; step(); dmem_rvalid_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid: wbv=%b req=%b rdy=%b want 0 0 1", wb_valid_o, dmem_req_o, ex_ready_o);
        end
        step();
        checks++;
        if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mid_late: wbv=%b want 0", wb_valid_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            mem_op_t op = mem_op_t'($urandom_range(1, 11));
            logic [63:0] addr = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) addr = addr & ~(64'(size_bytes(op)) - 64'd1);
            run_txn(op, addr, {$urandom(), $urandom()}, 5'($urandom_range(0, 31)), 1'($urandom()),
                    $urandom_range(0, 3), $urandom_range(0, 3), {$urandom(), $urandom()}, 1'($urandom()));
        end
    endtask

    initial begin
        rst = 1'b1; ex_valid_i = 1'b0; ex_result_i = '0; ex_store_data_i = '0;
        ex_rd_addr_i = '0; ex_reg_write_i = 1'b0; ex_mem_op_i = MEM_NONE;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        test_reset();
        test_mem_none();
        test_back_to_back();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
